// File: rtl/isa_pkg.sv
// Shared ISA constants: mnemonic codes, opcodes, funct values and field packers.
package isa_pkg;

  // Mnemonic codes; must match the control decoder's numbering.
  typedef enum logic [4:0] {
    MnAdd  = 5'd0,  MnSub  = 5'd1,  MnAnd = 5'd2,  MnOr  = 5'd3,
    MnNor  = 5'd4,  MnSll  = 5'd5,  MnSrl = 5'd6,  MnJr  = 5'd7,
    MnAddi = 5'd8,  MnAndi = 5'd9,  MnOri = 5'd10, MnLui = 5'd11,
    MnLw   = 5'd12, MnSw   = 5'd13, MnBeq = 5'd14, MnBne = 5'd15,
    MnJ    = 5'd16, MnJal  = 5'd17
  } mnem_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnJr  = 6'h08;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt,
                                        input logic [5:0] fn);
    return {OpRtype, rs, rt, rd, shamt, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; pointers carry a wrap bit for full/empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_d, wptr_q, rptr_d, rptr_q;
  logic             push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // Pointer next-state: flush wins over push/pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + (AW+1)'(1);
      if (pop_ok)  rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction descriptors into 32-bit words and streams them to program memory.
module instr_encoder #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              err
);
  import isa_pkg::*;

  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [ADDR_W:0]   count_d, count_q;
  logic              err_d, err_q;
  logic              rdy_d, rdy_q;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              fifo_full, fifo_empty;
  logic              accept, push, pop;

  // rdy_q keeps in_ready low until the first edge after reset release.
  assign in_ready = rdy_q & ~fifo_full & ~start;
  assign accept   = in_valid & in_ready;
  assign push     = accept & enc_legal;
  assign mem_we   = ~fifo_empty;
  assign pop      = mem_we & mem_ready & ~start;
  assign mem_addr = addr_q;
  assign count    = count_q;
  assign err      = err_q;

  // Combinational encoder: field masking per mnemonic, illegal codes flagged.
  always_comb begin
    enc_legal = 1'b1;
    enc_word  = '0;
    case (mnem)
      MnAdd:   enc_word = enc_r(rs, rt, rd, 5'd0, FnAdd);
      MnSub:   enc_word = enc_r(rs, rt, rd, 5'd0, FnSub);
      MnAnd:   enc_word = enc_r(rs, rt, rd, 5'd0, FnAnd);
      MnOr:    enc_word = enc_r(rs, rt, rd, 5'd0, FnOr);
      MnNor:   enc_word = enc_r(rs, rt, rd, 5'd0, FnNor);
      MnSll:   enc_word = enc_r(5'd0, rt, rd, shamt, FnSll);
      MnSrl:   enc_word = enc_r(5'd0, rt, rd, shamt, FnSrl);
      MnJr:    enc_word = enc_r(rs, 5'd0, 5'd0, 5'd0, FnJr);
      MnAddi:  enc_word = enc_i(OpAddi, rs, rt, imm);
      MnAndi:  enc_word = enc_i(OpAndi, rs, rt, imm);
      MnOri:   enc_word = enc_i(OpOri, rs, rt, imm);
      MnLui:   enc_word = enc_i(OpLui, 5'd0, rt, imm);
      MnLw:    enc_word = enc_i(OpLw, rs, rt, imm);
      MnSw:    enc_word = enc_i(OpSw, rs, rt, imm);
      MnBeq:   enc_word = enc_i(OpBeq, rs, rt, imm);
      MnBne:   enc_word = enc_i(OpBne, rs, rt, imm);
      MnJ:     enc_word = enc_j(OpJ, target);
      MnJal:   enc_word = enc_j(OpJal, target);
      default: enc_legal = 1'b0;
    endcase
  end

  // Address/count/error next-state; start overrides completion and accept.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    rdy_d   = 1'b1;
    if (start) begin
      addr_d  = base_addr;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (pop) begin
        addr_d  = addr_q + ADDR_W'(1);
        // MSB set only at the 2^ADDR_W ceiling.
        count_d = count_q[ADDR_W] ? count_q : count_q + (ADDR_W+1)'(1);
      end
      if (accept && !enc_legal) err_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (reset),
    .flush_i(start),
    .push_i (push),
    .wdata_i(enc_word),
    .pop_i  (pop),
    .rdata_o(mem_wdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: reference model plus directed literal checks.
module tb_instr_encoder;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  mnem = '0, rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic        mem_we;
  logic        mem_ready = 1'b0;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] count;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [31:0] mq[$];
  int          m_addr = 0;
  int          m_count = 0;
  bit          m_err = 1'b0;
  bit          m_rdy = 1'b0;
  // Log of completed writes as observed on the DUT outputs
  logic [9:0]  la[$];
  logic [31:0] ld[$];

  always #5 clk = ~clk;

  instr_encoder #(
    .ADDR_W(10),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .mnem(mnem), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .imm(imm), .target(target), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding from the instruction-format rules, in plain arithmetic.
  function automatic logic [31:0] model_enc(int m, int a, int b, int c, int d, int i, int t);
    int fn[8];
    int op[16];
    longint w;
    fn = '{32, 34, 36, 37, 39, 0, 2, 8};
    op = '{0, 0, 0, 0, 0, 0, 0, 0, 8, 12, 13, 15, 35, 43, 4, 5};
    if (m < 8) begin
      if (m == 5 || m == 6) a = 0;
      else d = 0;
      if (m == 7) begin b = 0; c = 0; d = 0; end
      w = longint'(a) * 2097152 + b * 65536 + c * 2048 + d * 64 + fn[m];
    end else if (m < 16) begin
      if (m == 11) a = 0;
      w = longint'(op[m]) * 67108864 + longint'(a) * 2097152 + b * 65536 + i;
    end else begin
      w = longint'(m == 16 ? 2 : 3) * 67108864 + t;
    end
    return w[31:0];
  endfunction

  // Reference model update on each clock edge / reset assertion.
  initial forever begin
    bit acc, cmp;
    @(posedge clk or negedge reset);
    if (!reset) begin
      mq.delete();
      m_addr = 0; m_count = 0; m_err = 1'b0; m_rdy = 1'b0;
    end else begin
      acc = in_valid && m_rdy && (mq.size() < DEPTH) && !start;
      cmp = (mq.size() > 0) && mem_ready;
      if (start) begin
        mq.delete();
        m_addr = int'(base_addr); m_count = 0; m_err = 1'b0;
      end else begin
        if (cmp) begin
          void'(mq.pop_front());
          m_addr = (m_addr + 1) % 1024;
          if (m_count < 1024) m_count++;
        end
        if (acc) begin
          if (mnem < 5'd18)
            mq.push_back(model_enc(int'(mnem), int'(rs), int'(rt), int'(rd), int'(shamt),
                                   int'(imm), int'(target)));
          else m_err = 1'b1;
        end
      end
      m_rdy = 1'b1;
    end
  end

  // Compare DUT against model mid-cycle; log writes that complete at the next edge.
  initial forever begin
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(m_rdy && (mq.size() < DEPTH) && !start));
    chk("mem_we", 32'(mem_we), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("mem_wdata", mem_wdata, mq[0]);
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("count", 32'(count), 32'(m_count));
    chk("err", 32'(err), 32'(m_err));
    if (mem_we && mem_ready && !start && reset) begin
      la.push_back(mem_addr);
      ld.push_back(mem_wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [9:0] b);
    start = 1'b1;
    base_addr = b;
    tick();
    start = 1'b0;
    la.delete();
    ld.delete();
  endtask

  task automatic push(input int m, input int a, input int b, input int c, input int d,
                      input int i, input int t);
    mnem = 5'(m); rs = 5'(a); rt = 5'(b); rd = 5'(c); shamt = 5'(d);
    imm = 16'(i); target = 26'(t);
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("push_timeout", 32'(1), 32'(0));
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (!mem_we) return;
      tick();
    end
    chk("drain_timeout", 32'(1), 32'(0));
  endtask

  task automatic chk_log(input int k, input logic [9:0] a, input logic [31:0] d);
    if (la.size() > k) begin
      chk($sformatf("log%0d_addr", k), 32'(la[k]), 32'(a));
      chk($sformatf("log%0d_data", k), ld[k], d);
    end else begin
      chk($sformatf("log%0d_missing", k), 32'(la.size()), 32'(k + 1));
    end
  endtask

  initial begin
    int we_seen;
    #2 reset = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_mem_we", 32'(mem_we), 32'(0));
    chk("rst_addr", 32'(mem_addr), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    reset = 1'b1;
    #1 chk("ready_before_edge", 32'(in_ready), 32'(0));
    tick();
    chk("ready_after_edge", 32'(in_ready), 32'(1));

    // addi visible at head one cycle after accept, held while mem_ready is low
    do_start(10'h000);
    push(8, 0, 8, 0, 0, 5, 0);
    chk("addi_we", 32'(mem_we), 32'(1));
    chk("addi_word", mem_wdata, 32'h2008_0005);
    chk("addi_addr", 32'(mem_addr), 32'(0));
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("addi_count", 32'(count), 32'(1));
    chk("addi_next_addr", 32'(mem_addr), 32'(1));

    // add / sll / lui back to back with streaming memory
    do_start(10'h010);
    mem_ready = 1'b1;
    push(0, 8, 9, 10, 0, 0, 0);
    push(5, 7, 3, 2, 4, 0, 0);
    push(11, 5, 1, 0, 0, 16'h1001, 0);
    drain();
    chk("seq_nwrites", 32'(la.size()), 32'(3));
    chk_log(0, 10'h010, 32'h0109_5020);
    chk_log(1, 10'h011, 32'h0003_1100);
    chk_log(2, 10'h012, 32'h3C01_1001);
    chk("seq_count", 32'(count), 32'(3));

    // j plus a sweep of the remaining mnemonics (model-checked)
    do_start(10'h000);
    push(16, 3, 3, 3, 3, 0, 26'h010_0000);
    push(1, 1, 2, 3, 7, 0, 0);
    push(2, 4, 5, 6, 1, 0, 0);
    push(3, 31, 30, 29, 28, 0, 0);
    push(6, 9, 10, 11, 31, 0, 0);
    push(10, 2, 3, 0, 0, 16'hABCD, 0);
    push(12, 29, 8, 0, 0, 16'hFFFC, 0);
    push(15, 1, 2, 0, 0, 16'h8000, 0);
    push(17, 0, 0, 0, 0, 0, 26'h3FF_FFFF);
    drain();
    chk_log(0, 10'h000, 32'h0810_0000);
    chk_log(8, 10'h008, 32'h0FFF_FFFF);

    // Stall: 4 fill the buffer, 5th refused, head stable, then ordered drain
    do_start(10'h020);
    mem_ready = 1'b0;
    push(10, 1, 2, 0, 0, 16'h00FF, 0);
    push(13, 29, 31, 0, 0, 16'h0004, 0);
    push(14, 4, 5, 0, 0, 16'hFFFF, 0);
    push(7, 31, 3, 7, 9, 0, 0);
    mnem = 5'd17; target = 26'h3FF_FFFF; in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'(0));
      chk("stall_we", 32'(mem_we), 32'(1));
      chk("stall_word", mem_wdata, 32'h3422_00FF);
      chk("stall_addr", 32'(mem_addr), 32'h020);
    end
    tick();
    in_valid = 1'b0;
    mem_ready = 1'b1;
    drain();
    chk("stall_nwrites", 32'(la.size()), 32'(4));
    chk_log(0, 10'h020, 32'h3422_00FF);
    chk_log(1, 10'h021, 32'hAFBF_0004);
    chk_log(2, 10'h022, 32'h1085_FFFF);
    chk_log(3, 10'h023, 32'h03E0_0008);

    // Address wrap from all-ones
    do_start(10'h3FF);
    push(4, 1, 2, 3, 5, 0, 0);
    push(9, 6, 7, 0, 0, 16'h8000, 0);
    drain();
    chk_log(0, 10'h3FF, 32'h0022_1827);
    chk_log(1, 10'h000, 32'h30C7_8000);

    // Illegal mnemonic: sticky err, no write; start clears it
    do_start(10'h000);
    push(20, 1, 2, 3, 4, 16'h1234, 0);
    chk("illegal_err", 32'(err), 32'(1));
    chk("illegal_we", 32'(mem_we), 32'(0));
    tick(); tick();
    chk("illegal_nwrites", 32'(la.size()), 32'(0));
    chk("illegal_err_hold", 32'(err), 32'(1));
    do_start(10'h005);
    chk("start_clears_err", 32'(err), 32'(0));

    // Reset with 3 words stalled: buffer discarded, no further strobes
    mem_ready = 1'b0;
    push(0, 1, 2, 3, 0, 0, 0);
    push(1, 4, 5, 6, 0, 0, 0);
    push(3, 7, 8, 9, 0, 0, 0);
    chk("queued_we", 32'(mem_we), 32'(1));
    #2 reset = 1'b0;
    #1;
    chk("rst_imm_we", 32'(mem_we), 32'(0));
    chk("rst_imm_ready", 32'(in_ready), 32'(0));
    chk("rst_imm_addr", 32'(mem_addr), 32'(0));
    tick(); tick();
    reset = 1'b1;
    mem_ready = 1'b1;
    we_seen = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (mem_we) we_seen++;
    end
    chk("no_we_after_reset", 32'(we_seen), 32'(0));

    // Long stream: count saturates at 1024, address wraps to 1030 mod 1024
    do_start(10'h000);
    for (int n = 0; n < 1030; n++) push(n % 18, n % 32, (n / 3) % 32, 5, n % 7, n * 37, n * 1001);
    drain();
    chk("sat_count", 32'(count), 32'(1024));
    chk("sat_addr", 32'(mem_addr), 32'(6));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the program-memory word-address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the encoded-word buffer depth (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that loads the write address from base_addr.
REQ-006 SHALL have port base_addr, input, ADDR_W bits: first word address of the program.
REQ-007 SHALL have port in_valid, input, 1 bit: an instruction descriptor is present.
REQ-008 SHALL have port in_ready, output, 1 bit: the descriptor is accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port mnem, input, 5 bits: mnemonic code per the package table.
REQ-010 SHALL have ports rs, rt, rd and shamt, input, 5 bits each: register and shift fields.
REQ-011 SHALL have port imm, input, 16 bits: immediate or branch offset.
REQ-012 SHALL have port target, input, 26 bits: jump target field.
REQ-013 SHALL have port mem_we, output, 1 bit: program-memory write strobe.
REQ-014 SHALL have port mem_ready, input, 1 bit: memory accepts a write this cycle.
REQ-015 SHALL have port mem_addr, output, ADDR_W bits: word address of the write.
REQ-016 SHALL have port mem_wdata, output, 32 bits: encoded instruction word.
REQ-017 SHALL have ports count (output, ADDR_W+1 bits, words written since start) and err (output, 1 bit, sticky illegal-mnemonic flag).

Function
REQ-018 SHALL encode R-type (add, sub, and, or, nor, sll, srl, jr) as op=0x00 | rs<<21 | rt<<16 | rd<<11 | shamt<<6 | funct, with funct 0x20, 0x22, 0x24, 0x25, 0x27, 0x00, 0x02, 0x08 respectively.
REQ-019 SHALL zero the rs field for sll/srl, zero the shamt field for non-shift R-types, and zero rt, rd and shamt for jr.
REQ-020 SHALL encode I-type as op<<26 | rs<<21 | rt<<16 | imm, with op: addi 0x08, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bne 0x05; lui SHALL force rs=0.
REQ-021 SHALL encode j and jal as op<<26 | target, with op 0x02 and 0x03.
REQ-022 SHALL write the encoded word into the FIFO on the accept cycle, so that it is visible at the FIFO head one cycle later.
REQ-023 SHALL drive in_ready = FIFO not full; simultaneous push and pop on a full FIFO SHALL NOT be accepted.
REQ-024 SHALL assert mem_we combinationally whenever the FIFO is non-empty; mem_wdata and mem_addr SHALL then show the head word and the current address.
REQ-025 SHALL treat a write as completing when mem_we and mem_ready are both high; on completion it SHALL pop the FIFO, increment mem_addr modulo 2^ADDR_W (wrapping from all-ones to 0), and increment count, saturating at 2^ADDR_W.
REQ-026 SHALL hold mem_addr, mem_wdata and mem_we stable while mem_ready is low.
REQ-027 SHALL handle an illegal mnemonic (codes 18 to 31) as follows: accept it, write nothing to the FIFO, and set err, which holds until reset or start.
REQ-028 On start SHALL flush the FIFO, load mem_addr from base_addr, clear count and clear err; in_ready SHALL be low during the start cycle, and start has priority over a concurrent accept or completion.
REQ-029 SHALL support simultaneous push and pop on a non-full, non-empty FIFO in one cycle, leaving the occupancy unchanged.

Reset
REQ-030 On reset low SHALL immediately clear the FIFO, and set mem_addr=0, count=0, err=0, mem_we=0 and in_ready=0; in_ready SHALL rise on the first clock edge after reset is released.
REQ-031 Reset asserted in the middle of a stalled write SHALL discard the buffered words without any further mem_we assertion.

Structure
REQ-032 SHALL place the mnemonic codes (add=0, sub=1, and=2, or=3, nor=4, sll=5, srl=6, jr=7, addi=8, andi=9, ori=10, lui=11, lw=12, sw=13, beq=14, bne=15, j=16, jal=17) and the opcode/funct constants in the shared package isa_pkg, matching the control decoder's values.
REQ-033 SHALL implement the buffer as the sub-module sync_fifo (WIDTH=32, DEPTH=FIFO_DEPTH), with the encoder kept as combinational logic ahead of it.

Verification
REQ-034 Bench SHALL apply addi with rs=0, rt=8, imm=5 after start with base_addr=0, and SHALL check mem_wdata=0x20080005 at mem_addr=0.
REQ-035 Bench SHALL apply add (rd=10, rs=8, rt=9), then sll (rd=2, rt=3, shamt=4), then lui (rt=1, imm=0x1001), with mem_ready high, and SHALL check the words 0x01095020, 0x00031100 and 0x3C011001 at consecutive addresses and count=3.
REQ-036 Bench SHALL apply j with target=0x100000 and SHALL check the word 0x08100000.
REQ-037 Bench SHALL hold mem_ready low and push 5 descriptors, and SHALL check in_ready low after 4, mem_we and data stable, then all 4 drained in order once mem_ready rises.
REQ-038 Bench SHALL start with base_addr=0x3FF and write 2 words, and SHALL check addresses 0x3FF then 0x000.
REQ-039 Bench SHALL apply mnem=20, and SHALL check err=1 and no write; a subsequent start SHALL clear err; reset asserted with 3 words queued SHALL produce no further mem_we.
